// File: rtl/soc_ram_pkg.sv
// rtl/soc_ram_pkg.sv - shared types, widths and byte-merge helper for the SoC RAM path
package soc_ram_pkg;

    localparam int SOC_RAM_DW   = 32;
    localparam int SOC_RAM_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RMW  = 2'd2,
        ST_RESP = 2'd3
    } soc_ram_state_e;

    // Lanes with sel set take the new byte, the rest keep the stored byte.
    function automatic logic [SOC_RAM_DW-1:0] soc_ram_merge(
        input logic [SOC_RAM_DW-1:0]   old_word,
        input logic [SOC_RAM_DW-1:0]   new_word,
        input logic [SOC_RAM_SELW-1:0] sel
    );
        logic [SOC_RAM_DW-1:0] res;
        res = old_word;
        for (int n = 0; n < SOC_RAM_SELW; n++) begin
            if (sel[n]) begin
                res[8*n +: 8] = new_word[8*n +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_ram_byte_merge.sv
// rtl/soc_ram_byte_merge.sv - combinational byte-lane merge of a new word into a stored word
module soc_ram_byte_merge
    import soc_ram_pkg::*;
(
    input  logic [SOC_RAM_DW-1:0]   old_word,
    input  logic [SOC_RAM_DW-1:0]   new_word,
    input  logic [SOC_RAM_SELW-1:0] sel,
    output logic [SOC_RAM_DW-1:0]   merged
);

    assign merged = soc_ram_merge(old_word, new_word, sel);

endmodule

// File: rtl/soc_ram_wb_ctrl.sv
// rtl/soc_ram_wb_ctrl.sv - Wishbone classic slave driving a registered-read single-port RAM
module soc_ram_wb_ctrl
    import soc_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH+1:0]   wb_adr_i,
    input  logic [SOC_RAM_SELW-1:0] wb_sel_i,
    input  logic [SOC_RAM_DW-1:0]   wb_dat_i,
    output logic [SOC_RAM_DW-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [SOC_RAM_DW-1:0]   ram_data,
    output logic                    ram_we,
    input  logic [SOC_RAM_DW-1:0]   ram_q
);

    soc_ram_state_e          state;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [SOC_RAM_SELW-1:0] lat_sel;
    logic [SOC_RAM_DW-1:0]   lat_dat;
    logic [SOC_RAM_DW-1:0]   merged;
    logic                    req;
    logic                    req_bad;
    logic                    full_wr;

    assign req     = wb_cyc_i & wb_stb_i;
    assign req_bad = (wb_adr_i[1:0] != 2'b00) || (wb_sel_i == '0);
    assign full_wr = req & wb_we_i & ~req_bad & (wb_sel_i == '1);

    soc_ram_byte_merge u_merge (
        .old_word (ram_q),
        .new_word (lat_dat),
        .sel      (lat_sel),
        .merged   (merged)
    );

    // In IDLE the address flows straight through so the RAM sees it in cycle 0.
    always_comb begin
        ram_addr = lat_addr;
        ram_data = lat_dat;
        ram_we   = 1'b0;
        case (state)
            ST_IDLE: begin
                ram_addr = wb_adr_i[ADDR_WIDTH+1:2];
                ram_data = wb_dat_i;
                ram_we   = full_wr;
            end
            ST_RMW: begin
                ram_data = merged;
                ram_we   = wb_cyc_i;
            end
            default: ;
        endcase
        if (!rst_n) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lat_addr <= '0;
            lat_sel  <= '0;
            lat_dat  <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        lat_addr <= wb_adr_i[ADDR_WIDTH+1:2];
                        lat_sel  <= wb_sel_i;
                        lat_dat  <= wb_dat_i;
                        if (req_bad) begin
                            wb_err_o <= 1'b1;
                            state    <= ST_RESP;
                        end else if (!wb_we_i) begin
                            state <= ST_RD;
                        end else if (wb_sel_i == '1) begin
                            wb_ack_o <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            state <= ST_RMW;
                        end
                    end
                end
                ST_RD: begin
                    if (!wb_cyc_i) begin
                        state <= ST_IDLE;
                    end else begin
                        wb_dat_o <= ram_q;
                        wb_ack_o <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
                ST_RMW: begin
                    if (!wb_cyc_i) begin
                        state <= ST_IDLE;
                    end else begin
                        wb_ack_o <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_ram_wb_ctrl.sv
// tb/tb_soc_ram_wb_ctrl.sv - self-checking bench for soc_ram_wb_ctrl with a RAM model and word-level reference
module tb_soc_ram_wb_ctrl;

    localparam int AW    = 10;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [AW+1:0] wb_adr_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_dat_i, wb_dat_o;
    logic          wb_ack_o, wb_err_o;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data, ram_q;
    logic          ram_we;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ram_mem [0:WORDS-1] = '{default: 32'h0};
    logic [31:0] exp_mem [0:WORDS-1] = '{default: 32'h0};

    soc_ram_wb_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered address (read-before-write).
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_data;
        ram_q <= ram_mem[ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // One transfer starting now (posedge+1); returns at posedge+1 of the IDLE cycle after the response.
    task automatic xfer(input logic we, input logic [AW+1:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input string tag);
        int          n, nwr, wcyc, exp_n;
        logic        bad, ack_seen, err_seen;
        logic [AW-1:0] word, waddr;
        logic [31:0] wdata, rd, expw;
        bad   = (adr % 4 != 0) || (sel == 4'h0);
        word  = adr[AW+1:2];
        expw  = (exp_mem[word] & ~lane_mask(sel)) | (dat & lane_mask(sel));
        exp_n = bad ? 1 : (!we ? 2 : (sel == 4'hF ? 1 : 2));
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        n = 0; nwr = 0; wcyc = -1; ack_seen = 0; err_seen = 0;
        waddr = '0; wdata = '0; rd = '0;
        while (n < 8) begin
            @(negedge clk);
            if (ram_we) begin nwr++; wcyc = n; waddr = ram_addr; wdata = ram_data; end
            if (wb_ack_o || wb_err_o) begin
                ack_seen = wb_ack_o; err_seen = wb_err_o; rd = wb_dat_o;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        chk({tag, " resp_cycle"}, n, exp_n);
        chk({tag, " ack"}, ack_seen, !bad);
        chk({tag, " err"}, err_seen, bad);
        chk({tag, " ram_writes"}, nwr, (we && !bad) ? 1 : 0);
        if (we && !bad) begin
            chk({tag, " write_cycle"}, wcyc, exp_n - 1);
            chk({tag, " write_addr"}, waddr, word);
            chk({tag, " write_data"}, wdata, expw);
            exp_mem[word] = expw;
        end else if (!we && !bad) begin
            chk({tag, " read_data"}, rd, exp_mem[word]);
        end
    endtask

    task automatic go_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    initial begin
        logic        r_we;
        logic [AW+1:0] r_adr;
        logic [3:0]  r_sel;
        logic [31:0] r_dat;
        rst_n = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 12'h014; wb_sel_i = 4'hF; wb_dat_i = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset ram_we", ram_we, 1'b0);
            chk("reset ack", wb_ack_o, 1'b0);
            chk("reset err", wb_err_o, 1'b0);
            chk("reset dat_o", wb_dat_o, 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1'b1, 12'h014, 4'hF, 32'hCAFE_F00D, "post_reset_wr");

        xfer(1'b1, 12'h010, 4'hF, 32'hDEAD_BEEF, "full_wr_w4");
        xfer(1'b0, 12'h010, 4'hF, 32'h0,         "rd_w4");
        xfer(1'b1, 12'h010, 4'b0110, 32'h00AA_5500, "partial_w4");
        chk("partial model", exp_mem[4], 32'hDEAA_55EF);
        xfer(1'b0, 12'h010, 4'hF, 32'h0,         "rd_w4_merged");

        xfer(1'b1, 12'h011, 4'hF, 32'h5555_5555, "err_misalign_wr");
        xfer(1'b1, 12'h010, 4'h0, 32'h6666_6666, "err_sel0_wr");
        xfer(1'b0, 12'h012, 4'hF, 32'h0,         "err_misalign_rd");
        xfer(1'b0, 12'h010, 4'hF, 32'h0,         "rd_w4_after_err");

        // Abort: drop cyc in the RMW cycle, then a read starts right away.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 12'h010; wb_sel_i = 4'b0011; wb_dat_i = 32'h1234_5678;
        @(negedge clk);
        chk("abort c0 ram_we", ram_we, 1'b0);
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        chk("abort c1 ram_we", ram_we, 1'b0);
        chk("abort c1 ack", wb_ack_o, 1'b0);
        @(posedge clk); #1;
        xfer(1'b0, 12'h010, 4'hF, 32'h0, "rd_w4_after_abort");

        for (int i = 0; i < 4; i++)
            xfer(1'b1, 12'(4 * i), 4'hF, 32'hA5A5_0000 + 32'(i * 32'h0101), $sformatf("fill_w%0d", i));
        for (int i = 0; i < 4; i++)
            xfer(1'b0, 12'(4 * i), 4'hF, 32'h0, $sformatf("b2b_rd_w%0d", i));

        xfer(1'b1, 12'hFFC, 4'hF, 32'h0BAD_F00D, "top_full_wr");
        xfer(1'b1, 12'hFFC, 4'b1001, 32'h7700_0033, "top_partial_wr");
        xfer(1'b0, 12'hFFC, 4'hF, 32'h0, "top_rd");
        go_idle();
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_adr = ($urandom_range(0, 1) != 0) ? 12'(4 * $urandom_range(0, 7))
                                                : 12'(4 * $urandom_range(WORDS - 4, WORDS - 1));
            if ($urandom_range(0, 9) == 0) r_adr = r_adr + 12'($urandom_range(1, 3));
            r_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) r_sel = 4'hF;
            r_dat = $urandom;
            xfer(r_we, r_adr, r_sel, r_dat, $sformatf("rand%0d", i));
            if ($urandom_range(0, 3) == 0) begin
                go_idle();
                @(posedge clk); #1;
            end
        end
        go_idle();

        for (int w = 0; w < 8; w++)
            xfer(1'b0, 12'(4 * w), 4'hF, 32'h0, $sformatf("final_rd_w%0d", w));
        go_idle();
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
